rll_key_loader: RTL

//   Upstream key-delivery stage for the 32-bit RLL-locked netlists (Stat_* family).

---
 rtl/rll_key_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rll_key_loader.sv
// Serial key loader for RLL-locked netlists: receives a framed, even-parity key
// over valid/ready, commits good keys, drives DECOY otherwise, locks out after repeated bad frames.
module rll_key_loader #(
    parameter int unsigned       KEY_W    = 32,
    parameter int unsigned       MAX_FAIL = 3,
    parameter logic [KEY_W-1:0]  DECOY    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    output logic             ser_ready,
    input  logic             ser_data,
    input  logic             ser_last,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             load_err,
    output logic             locked
);

    localparam int unsigned CNT_W  = $clog2(KEY_W + 2);
    localparam int unsigned FAIL_W = 4;

    localparam logic [CNT_W-1:0]  DATA_LEN  = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0]  FRAME_LEN = CNT_W'(KEY_W + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [KEY_W-1:0] shreg_q,     shreg_d;
    logic             par_q,       par_d;
    logic             bad_q,       bad_d;
    logic [FAIL_W-1:0] fail_q,     fail_d;
    logic [KEY_W-1:0] key_q,       key_d;
    logic             key_valid_q, key_valid_d;
    logic             load_err_q,  load_err_d;
    logic             locked_q,    locked_d;

    logic             accept_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             par_inc_c;

    // Ready is a pure state decode, held low while reset is asserted.
    assign ser_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_SHIFT));
    assign accept_c  = ser_valid && ser_ready;
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign par_inc_c = par_q ^ ser_data;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        bad_d       = bad_q;
        fail_d      = fail_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        load_err_d  = 1'b0;
        locked_d    = locked_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_d   = CNT_W'(1);
                    shreg_d = {ser_data, shreg_q[KEY_W-1:1]};
                    par_d   = ser_data;
                    if (ser_last) begin
                        // A one-bit frame can never be the right length.
                        bad_d      = 1'b1;
                        load_err_d = 1'b1;
                        state_d    = ST_CHECK;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (accept_c) begin
                    cnt_d = cnt_inc_c;
                    par_d = par_inc_c;
                    if (cnt_q < DATA_LEN) begin
                        shreg_d = {ser_data, shreg_q[KEY_W-1:1]};
                    end
                    if (ser_last || (cnt_inc_c == FRAME_LEN)) begin
                        bad_d      = (cnt_inc_c != FRAME_LEN) || !ser_last || par_inc_c;
                        load_err_d = bad_d;
                        state_d    = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                cnt_d = '0;
                par_d = 1'b0;
                bad_d = 1'b0;
                if (!bad_q) begin
                    key_d       = shreg_q;
                    key_valid_d = 1'b1;
                    fail_d      = '0;
                    state_d     = ST_IDLE;
                end else begin
                    key_d       = DECOY;
                    key_valid_d = 1'b0;
                    if (fail_q < FAIL_MAX) begin
                        fail_d = fail_q + FAIL_W'(1);
                    end
                    if ((fail_q + FAIL_W'(1)) >= FAIL_MAX) begin
                        locked_d = 1'b1;
                        state_d  = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCKED: begin
                key_d       = DECOY;
                key_valid_d = 1'b0;
                locked_d    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            bad_q       <= 1'b0;
            fail_q      <= '0;
            key_q       <= DECOY;
            key_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            bad_q       <= bad_d;
            fail_q      <= fail_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            load_err_q  <= load_err_d;
            locked_q    <= locked_d;
        end
    end

    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign load_err  = load_err_q;
    assign locked    = locked_q;

endmodule
